cache_mem_arbiter: RTL
======================

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 4: memory access time in cycles, legal range 1..15.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 i_mem_re  in  1  Icache read request, held high until i_drdy.
REQ-005 i_addr  in  16  Icache request word address.
REQ-006 d_mem_re / d_mem_we  in  1 each  Dcache read and write-back requests, held until d_drdy.
REQ-007 d_addr  in  16  Dcache request address; d_wdata  in  16  write-back data.
REQ-008 i_drdy / d_drdy  out  1 each  one-cycle completion pulse to the Icache or Dcache controller.
REQ-009 i_rdata / d_rdata  out  16  read data, valid only in the cycle its drdy is high.
REQ-010 mem_re / mem_we  out  1  memory strobes; mem_addr / mem_wdata  out  16  memory address and write data.
REQ-011 mem_rdata  in  16  memory read data, valid in the final busy cycle.

Function
REQ-012 States SHALL be IDLE, I_RD, D_RD and D_WR, plus a 4-bit busy counter cnt.
REQ-013 In IDLE, requests SHALL be sampled each cycle, and a grant SHALL move to the busy state on the next edge with cnt=0.
REQ-014 On the grant edge, the granted address and write data SHALL be latched, and mem_addr/mem_wdata SHALL hold those values for the whole transaction.
REQ-015 mem_re SHALL be high throughout I_RD and D_RD; mem_we SHALL be high throughout D_WR; both strobes SHALL be low in IDLE.
REQ-016 cnt SHALL increment each busy cycle, and the owner's drdy SHALL be high combinationally while cnt==LATENCY-1.
REQ-017 On the drdy edge, the state SHALL return to IDLE unconditionally, with no back-to-back grant.
REQ-018 A request asserted in cycle t with the arbiter idle SHALL see drdy in cycle t+LATENCY.
REQ-019 i_rdata and d_rdata SHALL both equal mem_rdata combinationally; this is only meaningful while the matching drdy is high.
REQ-020 If d_mem_re and d_mem_we are both high, the request SHALL be treated as a write (D_WR).
REQ-021 If a request drops mid-transaction, the transaction SHALL complete and the drdy pulse SHALL still be issued.
REQ-022 A write-back followed by a refill SHALL be handled as two separate transactions: the Dcache raises d_mem_re in the cycle after d_drdy, and the arbiter re-arbitrates it from IDLE.
REQ-023 The non-owning requester SHALL never see drdy.

Reset
REQ-024 While rst_n is low, the state SHALL be IDLE and cnt SHALL be 0.
REQ-025 While rst_n is low, mem_re, mem_we, i_drdy and d_drdy SHALL be 0, and the latched addr/wdata SHALL be 0.
REQ-026 Reset asserted mid-transaction SHALL abort it immediately, with no drdy pulse issued.
REQ-027 The first grant SHALL be possible in the first cycle after rst_n rises.

Configuration
REQ-028 Macro ARB_RR_EN defined: round-robin arbitration, with a last-grant flag (reset value: Icache last).
REQ-029 Macro ARB_RR_EN defined: on a simultaneous I and D request, the requester not granted last SHALL win.
REQ-030 Macro ARB_RR_EN undefined: fixed priority, with any Dcache request beating an Icache request; the last-grant flag is absent.

Verification
REQ-031 Scenario 1: LATENCY=4, i_mem_re=1 with i_addr=0x0040 at cycle 0 -> mem_re=1 and mem_addr=0x0040 in cycles 1-4; i_drdy=1 only in cycle 4 with i_rdata=mem_rdata; IDLE in cycle 5.
REQ-032 Scenario 2: d_mem_we=1 with d_addr=0x1230 and d_wdata=0xBEEF, then d_mem_re=1 the cycle after d_drdy -> D_WR transaction with mem_wdata=0xBEEF, then a separate D_RD; two distinct d_drdy pulses, 5 cycles apart.
REQ-033 Scenario 3: i_mem_re and d_mem_re both high at cycle 0, ARB_RR_EN undefined -> D served first (d_drdy cycle 4), then I served (i_drdy cycle 9).
REQ-034 Scenario 4: the same stimulus as scenario 3, repeated with ARB_RR_EN defined -> grants alternate D, I, D, I.
REQ-035 Scenario 5: rst_n pulled low at cnt=2 of a D_RD -> all outputs 0 immediately and no d_drdy; the request still held after reset is granted anew.
REQ-036 Scenario 6: LATENCY=1, i_mem_re held -> i_drdy high every second cycle, IDLE between pulses.

Source files
------------

// File: rtl/cache_mem_arbiter_if.sv
// Purpose : bundles the Icache, Dcache and memory-side signals of the cache/memory arbiter.
// Latency : none; wires only.
// Backpres: requests are level-held until the matching drdy pulse.
// Ports   : slave  = arbiter view (takes cache requests and mem_rdata, drives drdy/rdata and mem strobes)
//           master = requester/memory-model view (the mirror image of slave)
interface cache_mem_arbiter_if;
  // Icache side
  logic        i_mem_re;
  logic [15:0] i_addr;
  logic        i_drdy;
  logic [15:0] i_rdata;
  // Dcache side
  logic        d_mem_re;
  logic        d_mem_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_drdy;
  logic [15:0] d_rdata;
  // memory side
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport slave (
    input  i_mem_re, i_addr, d_mem_re, d_mem_we, d_addr, d_wdata, mem_rdata,
    output i_drdy, i_rdata, d_drdy, d_rdata, mem_re, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_mem_re, i_addr, d_mem_re, d_mem_we, d_addr, d_wdata, mem_rdata,
    input  i_drdy, i_rdata, d_drdy, d_rdata, mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Purpose : arbitrates Icache reads and Dcache reads/write-backs onto one fixed-latency memory port.
// Latency : request in cycle t (arbiter idle) -> drdy in cycle t+LATENCY; one idle cycle after every transaction.
// Backpres: requests stay high until drdy; a losing requester simply waits in IDLE for a later grant.
// Ports   : clk, rst_n (async, active-low); bus = cache_mem_arbiter_if.slave (see interface file).
// Params  : LATENCY (1..15) memory access time in cycles.
// Macro   : ARB_RR_EN defined -> round-robin between I and D; undefined -> Dcache has fixed priority.
module cache_mem_arbiter #(
  parameter int unsigned LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cache_mem_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, I_RD, D_RD, D_WR} state_t;

  // Value of cnt in the last busy cycle, when drdy fires.
  localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [15:0] addr_q, addr_nxt;
  logic [15:0] wdata_q, wdata_nxt;

  logic        i_req, d_req, grant_d;
  logic        done;
  logic        i_drdy, d_drdy, mem_re, mem_we;

  assign i_req = bus.i_mem_re;
  // A write-back request counts as a Dcache request even if d_mem_re is also high.
  assign d_req = bus.d_mem_re | bus.d_mem_we;
  assign done  = (cnt == CNT_LAST);

`ifdef ARB_RR_EN
  // last_d: 1 when the most recent grant went to the Dcache; resets as "Icache last".
  logic last_d, last_d_nxt;

  // On a tie the side that was not granted last wins.
  assign grant_d = d_req & (~i_req | ~last_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_d <= 1'b0;
    else        last_d <= last_d_nxt;
  end

  always_comb begin
    last_d_nxt = last_d;
    if (state == IDLE && (d_req || i_req)) last_d_nxt = grant_d;
  end
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    i_drdy    = 1'b0;
    d_drdy    = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = 4'd0;
        if (grant_d) begin
          state_nxt = bus.d_mem_we ? D_WR : D_RD;
          addr_nxt  = bus.d_addr;
          wdata_nxt = bus.d_wdata;
        end else if (i_req) begin
          state_nxt = I_RD;
          addr_nxt  = bus.i_addr;
          wdata_nxt = 16'd0;
        end
      end
      I_RD: begin
        mem_re = 1'b1;
        i_drdy = done;
      end
      D_RD: begin
        mem_re = 1'b1;
        d_drdy = done;
      end
      D_WR: begin
        mem_we = 1'b1;
        d_drdy = done;
      end
      default: state_nxt = IDLE;
    endcase

    // Busy states count up; the drdy cycle always returns to IDLE, so a
    // still-held request has to win arbitration again from scratch.
    if (state != IDLE) begin
      if (done) begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end else begin
        cnt_nxt = cnt + 4'd1;
      end
    end
  end

  assign bus.i_drdy    = i_drdy;
  assign bus.d_drdy    = d_drdy;
  assign bus.mem_re    = mem_re;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  // Read data is a straight pass-through; consumers qualify it with their drdy.
  assign bus.i_rdata   = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;

endmodule
